// File: rtl/mul_pkg.sv
// Shared definitions for the iterative RV32M multiplier: op encodings, FSM states, widths.
package mul_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 6;

  // funct3[1:0] of the RV32M multiply group
  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULH   = 2'b01;
  localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } mul_state_t;

endpackage

// File: rtl/cla_add_n.sv
// WIDTH-bit adder built from chained 4-bit carry-lookahead slices; WIDTH must be a multiple of 4.
module cla_add_n #(
  parameter int WIDTH = 36
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int N = WIDTH / 4;

  logic [N:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_slice
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] cs;

    assign p = x[4*i +: 4] ^ y[4*i +: 4];
    assign g = x[4*i +: 4] & y[4*i +: 4];

    // Every slice carry is formed directly from the slice carry-in, not rippled.
    assign cs[0] = c[i];
    assign cs[1] = g[0] | (p[0] & c[i]);
    assign cs[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[i]);
    assign cs[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[i]);
    assign c[i+1] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                  | (p[3] & p[2] & p[1] & p[0] & c[i]);

    assign sum[4*i +: 4] = p ^ cs;
  end

  assign cout = c[N];

endmodule

// File: rtl/mul_seq_rv32.sv
// Iterative shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU, one multiplier bit per cycle.
// Optional MUL_ZERO_BYPASS_EN: a zero operand skips straight to DONE with result 0.
module mul_seq_rv32 #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  import mul_pkg::*;

  localparam int ADD_W = 36;

  // Handshake: a request transfers on a rising edge with in_valid && in_ready (and no flush);
  // a result transfers on a rising edge with out_valid && out_ready. One op in flight at a time.

  mul_state_t      state;
  logic [1:0]      op_q;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [CNT_W-1:0] cnt;
  logic            neg;

  logic            a_signed;
  logic            b_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic            accept;

  assign a_signed = (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
  assign b_signed = (op == MUL_OP_MULH);
  assign a_neg    = a_signed & a[XLEN-1];
  assign b_neg    = b_signed & b[XLEN-1];
  // Two's-complement negate; 0x80000000 maps to itself, read as unsigned magnitude.
  assign abs_a    = a_neg ? (~a + XLEN'(1)) : a;
  assign abs_b    = b_neg ? (~b + XLEN'(1)) : b;
  assign accept   = (state == IDLE) && in_valid && !flush;

  logic [ADD_W-1:0] add_x;
  logic [ADD_W-1:0] add_y;
  logic [ADD_W-1:0] add_sum;
  logic             add_cout;
  logic             unused_add;

  assign add_x = {{(ADD_W-XLEN){1'b0}}, hi};
  assign add_y = {{(ADD_W-XLEN){1'b0}}, (lo[0] ? mcand : '0)};

  cla_add_n #(.WIDTH(ADD_W)) u_add (
    .x    (add_x),
    .y    (add_y),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Top adder bits are structurally zero; only sum[32:0] is meaningful.
  assign unused_add = &{1'b0, add_sum[ADD_W-1:XLEN+1], add_cout};

  logic [2*XLEN-1:0] prod_raw;
  logic [2*XLEN-1:0] prod;

  assign prod_raw = {hi, lo};
  assign prod     = neg ? (~prod_raw + (2*XLEN)'(1)) : prod_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      op_q      <= '0;
      mcand     <= '0;
      hi        <= '0;
      lo        <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q     <= op;
            mcand    <= abs_a;
            hi       <= '0;
            lo       <= abs_b;
            cnt      <= '0;
            neg      <= a_neg ^ b_neg;
            in_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef MUL_ZERO_BYPASS_EN
            if ((a == '0) || (b == '0)) begin
              result    <= '0;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= CALC;
            end
`else
            state <= CALC;
`endif
          end
        end
        CALC: begin
          if (flush) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            hi  <= add_sum[XLEN:1];
            lo  <= {add_sum[0], lo[XLEN-1:1]};
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(XLEN-1)) begin
              state <= FIXUP;
            end
          end
        end
        FIXUP: begin
          if (flush) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            result    <= (op_q == MUL_OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (flush || out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_rv32.sv
// Self-checking bench for mul_seq_rv32: directed corner ops, backpressure, flush, async reset, random ops.
module tb_mul_seq_rv32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

`ifdef MUL_ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  mul_seq_rv32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] xe;
    logic [63:0] ye;
    logic [63:0] p;
    xe = (o == 2'b01 || o == 2'b10) ? {{32{x[31]}}, x} : {32'h0, x};
    ye = (o == 2'b01) ? {{32{y[31]}}, y} : {32'h0, y};
    p  = xe * ye;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic drive_req(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit push);
    int n;
    in_valid = 1'b1;
    op = o;
    a  = x;
    b  = y;
    n  = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      n_cmp++; n_err++;
      $display("FAIL drive_req_timeout: in_ready=%0b after %0d cycles, need 1", in_ready, n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    a  = $urandom;
    b  = $urandom;
    op = 2'($urandom_range(0, 3));
    if (push) exp_q.push_back(model(o, x, y));
  endtask

  // lat counts edges with the accept edge as 1; first out_valid high after edge lat.
  task automatic wait_out(output int lat, output bit busy_ok);
    lat = 1;
    busy_ok = 1'b1;
    while (!out_valid && lat < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (!busy) busy_ok = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b need 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b need 0", out_valid); end
    n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL reset_result: got %h need 0", result); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b need 0", busy); end
  endtask

  task automatic test_basic_mul();
    int lat; bit busy_ok; logic [31:0] e;
    out_ready = 1'b1;
    drive_req(2'b00, 32'd7, 32'd6, 1'b1);
    wait_out(lat, busy_ok);
    n_cmp++; if (lat != 34) begin n_err++; $display("FAIL basic_latency: got %0d need 34", lat); end
    n_cmp++; if (!busy_ok) begin n_err++; $display("FAIL basic_busy: busy dropped during op, need high throughout"); end
    e = exp_q.pop_front();
    n_cmp++; if (result !== e) begin n_err++; $display("FAIL basic_result: got %h need %h", result, e); end
    n_cmp++; if (result !== 32'h2A) begin n_err++; $display("FAIL basic_const: got %h need 0000002a", result); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL basic_handoff: out_valid=%b in_ready=%b need 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_signed_ops();
    logic [1:0]  t_op[5];
    logic [31:0] t_a[5];
    logic [31:0] t_b[5];
    logic [31:0] t_r[5];
    int lat; bit busy_ok; logic [31:0] e;
    t_op = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b01};
    t_a  = '{32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    t_b  = '{32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000002};
    t_r  = '{32'h40000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_req(t_op[i], t_a[i], t_b[i], 1'b0);
      exp_q.push_back(t_r[i]);
      wait_out(lat, busy_ok);
      e = exp_q.pop_front();
      n_cmp++; if (result !== e || out_valid !== 1'b1) begin
        n_err++; $display("FAIL signed_op%0d: op=%0d result=%h valid=%b need %h valid=1", i, t_op[i], result, out_valid, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int lat; bit busy_ok; logic [31:0] e;
    out_ready = 1'b0;
    drive_req(2'b00, 32'h12345678, 32'h9ABCDEF0, 1'b1);
    wait_out(lat, busy_ok);
    e = exp_q.pop_front();
    n_cmp++; if (result !== e) begin n_err++; $display("FAIL bp_result: got %h need %h", result, e); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b1 || result !== e || in_ready !== 1'b0) begin
        n_err++; $display("FAIL bp_hold%0d: valid=%b result=%h in_ready=%b need 1/%h/0", i, out_valid, result, in_ready, e);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_release: valid=%b in_ready=%b need 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_flush();
    int lat; bit busy_ok; bit seen; logic [31:0] e;
    out_ready = 1'b1;
    drive_req(2'b00, 32'h0000DEAD, 32'h0000BEEF, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_cmp++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_calc: busy=%b in_ready=%b valid=%b need 0/1/0", busy, in_ready, out_valid);
    end
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    n_cmp++; if (seen) begin n_err++; $display("FAIL flush_no_valid: out_valid seen=1 need 0"); end
    in_valid = 1'b1; flush = 1'b1; a = 32'd9; b = 32'd9; op = 2'b00;
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL flush_idle_block: busy=%b in_ready=%b need 0/1", busy, in_ready);
    end
    in_valid = 1'b0; flush = 1'b0;
    drive_req(2'b00, 32'd3, 32'd5, 1'b1);
    wait_out(lat, busy_ok);
    n_cmp++; if (lat != 34) begin n_err++; $display("FAIL flush_recover_latency: got %0d need 34", lat); end
    e = exp_q.pop_front();
    n_cmp++; if (result !== e || result !== 32'd15) begin
      n_err++; $display("FAIL flush_recover_result: got %h need %h", result, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    drive_req(2'b01, 32'h00000011, 32'h00000022, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL areset_ctrl: busy=%b valid=%b in_ready=%b need 0/0/1", busy, out_valid, in_ready);
    end
    n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL areset_result: got %h need 0", result); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_operand();
    int lat; bit busy_ok; logic [31:0] e; int exp_lat;
    exp_lat = BYPASS ? 1 : 34;
    out_ready = 1'b1;
    drive_req(2'b00, 32'h0, 32'h00001234, 1'b1);
    wait_out(lat, busy_ok);
    n_cmp++; if (lat != exp_lat) begin n_err++; $display("FAIL zero_latency: got %0d need %0d", lat, exp_lat); end
    e = exp_q.pop_front();
    n_cmp++; if (result !== e || result !== 32'h0) begin n_err++; $display("FAIL zero_result: got %h need 0", result); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat; bit busy_ok; logic [31:0] e; logic [31:0] x; logic [31:0] y; logic [1:0] o; int exp_lat;
    logic [31:0] corners[5];
    corners = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      o = 2'($urandom_range(0, 3));
      x = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      y = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      exp_lat = (BYPASS && (x == 0 || y == 0)) ? 1 : 34;
      drive_req(o, x, y, 1'b1);
      wait_out(lat, busy_ok);
      e = exp_q.pop_front();
      n_cmp++; if (result !== e || lat != exp_lat) begin
        n_err++; $display("FAIL b2b%0d: op=%0d a=%h b=%h result=%h lat=%0d need %h lat=%0d", i, o, x, y, result, lat, e, exp_lat);
      end
    end
    @(posedge clk); #1;
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_leftover: %0d entries need 0", exp_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_basic_mul();
    test_signed_ops();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_zero_operand();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
